// File: rtl/pipe_pkg.sv
// Shared defaults and occupancy-state names for the IF/ID pipeline stage register.
package pipe_pkg;

  localparam int PC_W_DEF    = 32;
  localparam int INSTR_W_DEF = 32;
  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR_DEF = '0;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_e;

  // Occupancy is never stored separately; it is always recovered from the two valid flags.
  function automatic state_e state_of(input logic main_v, input logic skid_v);
    return skid_v ? FULL : (main_v ? ONE : EMPTY);
  endfunction

endpackage

// File: rtl/pipe_entry.sv
// One valid+payload register. Clear drops valid and rewrites the payload bits selected
// by CLR_MASK with CLR_VAL; the other bits keep their last value.
module pipe_entry #(
  parameter int W = 8,
  parameter logic [W-1:0] RST_VAL  = '0,
  parameter logic [W-1:0] CLR_MASK = '0,
  parameter logic [W-1:0] CLR_VAL  = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] d,
  output logic         valid,
  output logic [W-1:0] q
);

  logic         valid_reg;
  logic [W-1:0] q_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_reg <= 1'b0;
      q_reg     <= RST_VAL;
    end else if (clear) begin
      valid_reg <= 1'b0;
      q_reg     <= (q_reg & ~CLR_MASK) | (CLR_VAL & CLR_MASK);
    end else if (load) begin
      valid_reg <= 1'b1;
      q_reg     <= d;
    end
  end

  assign valid = valid_reg;
  assign q     = q_reg;

endmodule

// File: rtl/pipe_stage_reg.sv
// IF/ID stage register built as a two-entry skid buffer (main drives outputs, skid absorbs a stall).
// Define PIPE_STAGE_PERF_EN to add the saturating stall_cnt / flush_cnt outputs.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int PC_W    = PC_W_DEF,
  parameter int INSTR_W = INSTR_W_DEF,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(NOP_INSTR_DEF)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc4,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc4,
  output logic [INSTR_W-1:0] out_instr
`ifdef PIPE_STAGE_PERF_EN
  ,
  output logic [15:0]        stall_cnt,
  output logic [15:0]        flush_cnt
`endif
);

  localparam int PW = PC_W + INSTR_W;
  localparam logic [PW-1:0] MAIN_RST  = {{PC_W{1'b0}}, NOP_INSTR};
  localparam logic [PW-1:0] MAIN_MASK = {{PC_W{1'b0}}, {INSTR_W{1'b1}}};

  logic          main_valid, skid_valid;
  logic [PW-1:0] main_q, skid_q, main_d, in_payload;
  logic          main_load, main_clear, skid_load, skid_clear;
  logic          accept, drain, skid_valid_next;
  logic          in_ready_reg, in_ready_next;
  state_e        state;

  assign in_payload = {in_pc4, in_instr};
  assign state      = state_of(main_valid, skid_valid);
  assign accept     = in_valid & in_ready_reg;
  assign drain      = main_valid & out_ready;
  assign main_d     = skid_valid ? skid_q : in_payload;

  always_comb begin
    main_load  = 1'b0;
    main_clear = 1'b0;
    skid_load  = 1'b0;
    skid_clear = 1'b0;
    case (state)
      EMPTY: main_load = accept;
      ONE: begin
        main_load  = drain & accept;
        main_clear = drain & ~accept;
        skid_load  = accept & ~drain;
      end
      FULL: begin
        main_load  = drain;
        skid_clear = drain;
      end
      default: ;
    endcase
    // Flush wins over every handshake: both entries are emptied and the incoming beat is dropped.
    if (flush) begin
      main_load  = 1'b0;
      skid_load  = 1'b0;
      main_clear = 1'b1;
      skid_clear = 1'b1;
    end
  end

  assign skid_valid_next = skid_load | (skid_valid & ~skid_clear);
  assign in_ready_next   = ~skid_valid_next;

  always_ff @(posedge clk) begin
    if (!rst_n) in_ready_reg <= 1'b1;
    else        in_ready_reg <= in_ready_next;
  end

  pipe_entry #(
    .W(PW), .RST_VAL(MAIN_RST), .CLR_MASK(MAIN_MASK), .CLR_VAL(MAIN_RST)
  ) u_main (
    .clk(clk), .rst_n(rst_n), .load(main_load), .clear(main_clear),
    .d(main_d), .valid(main_valid), .q(main_q)
  );

  pipe_entry #(
    .W(PW), .RST_VAL('0), .CLR_MASK('0), .CLR_VAL('0)
  ) u_skid (
    .clk(clk), .rst_n(rst_n), .load(skid_load), .clear(skid_clear),
    .d(in_payload), .valid(skid_valid), .q(skid_q)
  );

  assign in_ready  = in_ready_reg;
  assign out_valid = main_valid;
  assign out_pc4   = main_q[PW-1:INSTR_W];
  assign out_instr = main_q[INSTR_W-1:0];

`ifdef PIPE_STAGE_PERF_EN
  logic [1:0] perf_inc;
  assign perf_inc = {flush, main_valid & ~out_ready};

  for (genvar gi = 0; gi < 2; gi++) begin : g_perf
    logic [15:0] cnt_reg;
    always_ff @(posedge clk) begin
      if (!rst_n)
        cnt_reg <= '0;
      else if (perf_inc[gi] && cnt_reg != 16'hFFFF)
        cnt_reg <= cnt_reg + 16'd1;
    end
  end

  assign stall_cnt = g_perf[0].cnt_reg;
  assign flush_cnt = g_perf[1].cnt_reg;
`endif

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg: stimulus pushes surviving beats, a monitor pops on each drain.
// Build with PIPE_STAGE_PERF_EN defined to exercise the performance counters as well.
module tb_pipe_stage_reg;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, flush, out_ready;
  logic        in_ready, out_valid;
  logic [31:0] in_pc4, in_instr, out_pc4, out_instr;
`ifdef PIPE_STAGE_PERF_EN
  logic [15:0] stall_cnt, flush_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  pipe_stage_reg #(.PC_W(32), .INSTR_W(32), .NOP_INSTR(NOP)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_pc4(in_pc4), .in_instr(in_instr), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc4(out_pc4), .out_instr(out_instr)
`ifdef PIPE_STAGE_PERF_EN
    , .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    in_valid = v;
    in_pc4   = pc;
    in_instr = ins;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'd0);
    chk({tag, "_in_ready"},  64'(in_ready),  64'd1);
    chk({tag, "_out_pc4"},   64'(out_pc4),   64'd0);
    chk({tag, "_out_instr"}, 64'(out_instr), 64'(NOP));
  endtask

  // Monitor: a drain is a sampled out_valid & out_ready with no flush/reset in that cycle.
  initial begin
    logic [63:0] exp;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && flush === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_beat", {out_pc4, out_instr}, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          exp = sb_q.pop_front();
          chk("beat", {out_pc4, out_instr}, exp);
          $display("beat pc4=%0d instr=%h (expected %h)", out_pc4, out_instr, exp[31:0]);
        end
      end else if (rst_n === 1'b1 && out_valid === 1'b0) begin
        chk("idle_nop", 64'(out_instr), 64'(NOP));
      end
    end
  end

  initial begin
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs = '{32'd4, 32'd8, 32'd12};
    ins = '{32'hAAAA_0001, 32'hBBBB_0002, 32'hCCCC_0003};

    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    tick(); tick();
    chk_reset_state("reset");
    rst_n = 1'b1;
    tick();

    // Streaming at full rate
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, pcs[i], ins[i]);
      sb_q.push_back({pcs[i], ins[i]});
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      tick();
      chk("stream_latency_pc4", 64'(out_pc4), 64'(pcs[i]));
    end
    drive(1'b0, 32'd0, 32'd0);
    chk("stream_in_ready_end", 64'(in_ready), 64'd1);
    tick();
    chk("stream_empty", 64'(out_valid), 64'd0);
    $display("stream phase done");

    // Stall: A then B fill both entries
    out_ready = 1'b0;
    drive(1'b1, 32'd4, ins[0]); sb_q.push_back({32'd4, ins[0]}); tick();
    chk("stall_in_ready_one", 64'(in_ready), 64'd1);
    drive(1'b1, 32'd8, ins[1]); sb_q.push_back({32'd8, ins[1]}); tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    chk("full_out_pc4", 64'(out_pc4), 64'd4);
    tick();
    chk("full_hold_instr", 64'(out_instr), 64'(ins[0]));
    out_ready = 1'b1;
    tick();
    chk("unstall_in_ready", 64'(in_ready), 64'd1);
    chk("unstall_out_pc4", 64'(out_pc4), 64'd8);
    tick();
    chk("unstall_empty", 64'(out_valid), 64'd0);
    $display("stall phase done");

    // Flush while FULL with C offered
    out_ready = 1'b0;
    drive(1'b1, 32'd4, ins[0]); tick();
    drive(1'b1, 32'd8, ins[1]); tick();
    drive(1'b1, 32'd12, ins[2]);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("flush_out_valid", 64'(out_valid), 64'd0);
    chk("flush_out_instr", 64'(out_instr), 64'(NOP));
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_no_c", 64'(out_valid), 64'd0);

    // Flush in ONE while a beat is accepted: the incoming beat must be dropped too
    out_ready = 1'b0;
    drive(1'b1, 32'd20, 32'hEEEE_0005); tick();
    drive(1'b1, 32'd24, 32'hFFFF_0006);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(1'b0, 32'd0, 32'd0);
    chk("flush_one_out_valid", 64'(out_valid), 64'd0);
    chk("flush_one_in_ready", 64'(in_ready), 64'd1);
    chk("flush_one_pc4_held", 64'(out_pc4), 64'd20);
    $display("flush phase done");

    // Reset with concurrent flush while FULL
    drive(1'b1, 32'd4, ins[0]); tick();
    drive(1'b1, 32'd8, ins[1]); tick();
    drive(1'b0, 32'd0, 32'd0);
    rst_n = 1'b0; flush = 1'b1;
    tick();
    rst_n = 1'b1; flush = 1'b0;
    chk_reset_state("reset_full");
    out_ready = 1'b1;
    drive(1'b1, 32'd16, 32'hDDDD_0004); sb_q.push_back({32'd16, 32'hDDDD_0004});
    tick();
    drive(1'b0, 32'd0, 32'd0);
    chk("post_reset_d_pc4", 64'(out_pc4), 64'd16);
    tick();
    chk("post_reset_alone", 64'(out_valid), 64'd0);
    $display("reset phase done");

`ifdef PIPE_STAGE_PERF_EN
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    chk("perf_reset_flush", 64'(flush_cnt), 64'd0);
    for (int i = 0; i < 3; i++) begin
      flush = 1'b1; tick(); flush = 1'b0; tick();
    end
    chk("perf_flush_cnt", 64'(flush_cnt), 64'd3);
    out_ready = 1'b0;
    drive(1'b1, 32'd28, 32'h1234_5678); tick();
    drive(1'b0, 32'd0, 32'd0);
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    chk("perf_stall_sat", 64'(stall_cnt), 64'hFFFF);
    flush = 1'b1; tick(); flush = 1'b0;
    $display("perf phase done");
`else
    $display("perf counters not built");
`endif

    out_ready = 1'b1;
    for (int i = 0; i < 20 && sb_q.size() != 0; i++) tick();
    chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter PC_W, default 32, width of the PC+4 field.
REQ-002 Parameter INSTR_W, default 32, width of the instruction field.
REQ-003 Parameter NOP_INSTR, default all-zero of INSTR_W, instruction value presented when empty or flushed.
REQ-004 clk  in  1  sole clock; all state SHALL update on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 in_valid  in  1  upstream (IF) beat present.
REQ-007 in_ready  out  1  stage can accept a beat; SHALL be a pure register output.
REQ-008 in_pc4  in  PC_W  upstream PC+4.
REQ-009 in_instr  in  INSTR_W  upstream instruction.
REQ-010 flush  in  1  discard all held and incoming beats (branch/jump taken).
REQ-011 out_valid  out  1  downstream (ID) beat present.
REQ-012 out_ready  in  1  downstream accepts; low = stall.
REQ-013 out_pc4  out  PC_W  held PC+4.
REQ-014 out_instr  out  INSTR_W  held instruction.

Function
REQ-015 Two-entry skid buffer: main entry drives outputs; skid entry absorbs one beat when downstream stalls.
REQ-016 States: EMPTY (none valid), ONE (main valid), FULL (main+skid valid); state SHALL be derivable from two valid flags.
REQ-017 Accept = in_valid & in_ready; Drain = out_valid & out_ready.
REQ-018 EMPTY: accept -> ONE, beat loaded into main, out_valid high next cycle (latency 1).
REQ-019 ONE: accept & drain -> ONE with new beat in main; drain only -> EMPTY; accept only -> FULL, beat into skid; neither -> ONE, data held.
REQ-020 FULL: drain -> ONE, skid moved to main; no drain -> FULL, data held.
REQ-021 in_ready SHALL be registered ~skid_valid; in FULL in_ready=0, so no beat is lost or duplicated.
REQ-022 Beats SHALL leave in arrival order; no beat dropped except by flush.
REQ-023 flush=1 SHALL have priority over accept, drain and stall: next cycle state EMPTY, in_ready=1, out_instr=NOP_INSTR, same-cycle incoming beat discarded.
REQ-024 When out_valid=0, out_instr SHALL equal NOP_INSTR; out_pc4 SHALL hold last value.
REQ-025 Outputs SHALL be registered; no combinational path from in_* or out_ready to any output.

Reset
REQ-026 rst_n=0 at a clock edge SHALL force: state EMPTY, out_valid=0, in_ready=1, out_pc4=0, out_instr=NOP_INSTR, skid contents=0.
REQ-027 Reset SHALL override flush and any handshake in the same cycle; reset mid-FULL discards both entries.

Configuration
REQ-028 Macro PIPE_STAGE_PERF_EN, when defined, SHALL add outputs stall_cnt (16 bits, increments each cycle out_valid=1 & out_ready=0) and flush_cnt (16 bits, increments each cycle flush=1), both saturating at 16'hFFFF, cleared by reset.
REQ-029 Without PIPE_STAGE_PERF_EN the ports and counters SHALL be absent; remaining behaviour identical.

Structure
REQ-030 Shared package pipe_pkg SHALL hold default PC_W, INSTR_W, NOP_INSTR and the state-name constants EMPTY/ONE/FULL.
REQ-031 A single sub-module pipe_entry (valid+payload register with load/clear) SHALL be instantiated twice (main, skid); no other sub-modules.

Verification
REQ-032 Streaming: out_ready=1, beats pc4=4,8,12 instr=A,B,C on consecutive cycles -> same sequence on outputs one cycle later, in_ready constant 1.
REQ-033 Stall: load pc4=4/A then pc4=8/B with out_ready=0 -> out holds 4/A, in_ready=0 after B accepted; raise out_ready -> 4/A then 8/B, in_ready=1 again.
REQ-034 Flush in FULL with in_valid=1 pc4=12/C -> next cycle out_valid=0, out_instr=NOP_INSTR, in_ready=1, C never appears.
REQ-035 Reset in FULL (rst_n=0 one cycle, flush=1 concurrently) -> all REQ-026 values; subsequent beat pc4=16/D emerges alone.
REQ-036 PIPE_STAGE_PERF_EN defined: 70000 stall cycles -> stall_cnt=16'hFFFF; 3 flush pulses -> flush_cnt=3.
